// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point type, escape radius constant and the default colour gradient.
package mandel_pkg;

  localparam int W_DEF    = 18;
  localparam int FRAC_DEF = 13;

  typedef logic signed [W_DEF-1:0] fix_t;

  localparam int FOUR = 4 << FRAC_DEF;

  // R is the count shifted up to 8 bits (clamped), G its complement, B a fixed tint.
  function automatic logic [23:0] gradient(input logic [7:0] cnt, input int cw);
    logic [15:0] sh;
    logic [7:0]  r;
    if (cw >= 8) begin
      sh = {8'h00, cnt};
    end else begin
      sh = {8'h00, cnt} << (8 - cw);
    end
    if (sh > 16'h00FF) begin
      r = 8'hFF;
    end else begin
      r = sh[7:0];
    end
    return {8'h40, ~r, r};
  endfunction

endpackage

// File: rtl/mandel_stage.sv
// mandel_stage: one registered z <- z^2 + c iteration with escape detection.
module mandel_stage
  import mandel_pkg::*;
#(
  parameter int W    = 18,
  parameter int FRAC = 13,
  parameter int CW   = 5
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic signed [W-1:0] i_zx,
  input  logic signed [W-1:0] i_zy,
  input  logic signed [W-1:0] i_cx,
  input  logic signed [W-1:0] i_cy,
  input  logic [CW-1:0]       i_cnt,
  input  logic                i_esc,
  output logic signed [W-1:0] o_zx,
  output logic signed [W-1:0] o_zy,
  output logic signed [W-1:0] o_cx,
  output logic signed [W-1:0] o_cy,
  output logic [CW-1:0]       o_cnt,
  output logic                o_esc
);

  localparam logic [W+1:0] FOUR_W = (W+2)'(32'd4) << FRAC;

  logic signed [2*W-1:0] zx_w_s;
  logic signed [2*W-1:0] zy_w_s;
  logic signed [2*W-1:0] xx_full_s;
  logic signed [2*W-1:0] yy_full_s;
  logic signed [2*W-1:0] xy_full_s;
  logic [W+1:0]          mag_s;
  logic signed [W-1:0]   nx_s;
  logic signed [W-1:0]   ny_s;

  // Squares and cross term of the incoming z; the magnitude test uses z before the update.
  always_comb begin
    zx_w_s    = (2*W)'(i_zx);
    zy_w_s    = (2*W)'(i_zy);
    xx_full_s = zx_w_s * zx_w_s;
    yy_full_s = zy_w_s * zy_w_s;
    xy_full_s = zx_w_s * zy_w_s;
    mag_s     = (W+2)'(xx_full_s >>> FRAC) + (W+2)'(yy_full_s >>> FRAC);
    nx_s      = W'(xx_full_s >>> FRAC) - W'(yy_full_s >>> FRAC) + i_cx;
    ny_s      = W'(xy_full_s >>> (FRAC - 1)) + i_cy;
  end

  // Iteration register: escaped pixels freeze, others advance and count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_zx  <= '0;
      o_zy  <= '0;
      o_cx  <= '0;
      o_cy  <= '0;
      o_cnt <= '0;
      o_esc <= 1'b0;
    end else begin
      o_cx <= i_cx;
      o_cy <= i_cy;
      if (i_esc) begin
        o_zx  <= i_zx;
        o_zy  <= i_zy;
        o_cnt <= i_cnt;
        o_esc <= 1'b1;
      end else if (mag_s > FOUR_W) begin
        o_zx  <= i_zx;
        o_zy  <= i_zy;
        o_cnt <= i_cnt;
        o_esc <= 1'b1;
      end else begin
        o_zx  <= nx_s;
        o_zy  <= ny_s;
        o_cnt <= i_cnt + {{(CW-1){1'b0}}, 1'b1};
        o_esc <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_image_gen.sv
// mandelbrot_image_gen: pipelined Mandelbrot pixel generator, latency N_ITER+2, one pixel per clock.
// Define MANDEL_PALETTE_LUT_EN for a writable 16-entry colour palette.
module mandelbrot_image_gen
  import mandel_pkg::*;
#(
  parameter int XW     = 10,
  parameter int YW     = 10,
  parameter int W      = 18,
  parameter int FRAC   = 13,
  parameter int N_ITER = 16
)(
  input  logic          i_clk,
  input  logic          i_rst,
`ifdef MANDEL_PALETTE_LUT_EN
  input  logic          i_pal_we,
  input  logic [3:0]    i_pal_addr,
  input  logic [23:0]   i_pal_data,
`endif
  input  logic          i_de,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [W-1:0]  i_cx0,
  input  logic [W-1:0]  i_cy0,
  input  logic [W-1:0]  i_step,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic [23:0]   o_bgr
);

  localparam int CW = $clog2(N_ITER + 1);
  localparam int L  = N_ITER + 2;

  generate
    if (W - FRAC < 4) begin : g_fmt_check
      $error("mandelbrot_image_gen: W-FRAC must be at least 4");
    end
  endgenerate

  logic                vs_r;
  logic [W-1:0]        cx0_r;
  logic [W-1:0]        cy0_r;
  logic [W-1:0]        step_r;
  logic signed [W-1:0] m_cx_r;
  logic signed [W-1:0] m_cy_r;
  logic [L-1:0]        de_sr_r;
  logic [L-1:0]        hs_sr_r;
  logic [L-1:0]        vs_sr_r;
  logic [23:0]         bgr_r;
  logic [23:0]         esc_colour_s;
  logic [23:0]         colour_s;

  logic signed [W-1:0] zx_a  [0:N_ITER];
  logic signed [W-1:0] zy_a  [0:N_ITER];
  logic signed [W-1:0] cx_a  [0:N_ITER];
  logic signed [W-1:0] cy_a  [0:N_ITER];
  logic [CW-1:0]       cnt_a [0:N_ITER];
  logic                esc_a [0:N_ITER];

  // Config shadows load only on the vsync rising edge so a frame never mixes two views.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_r   <= 1'b0;
      cx0_r  <= '0;
      cy0_r  <= '0;
      step_r <= '0;
    end else begin
      vs_r <= i_vs;
      if (i_vs && !vs_r) begin
        cx0_r  <= i_cx0;
        cy0_r  <= i_cy0;
        step_r <= i_step;
      end else begin
        cx0_r  <= cx0_r;
        cy0_r  <= cy0_r;
        step_r <= step_r;
      end
    end
  end

  // Map stage: screen coordinate to c, all arithmetic modulo 2^W.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_cx_r <= '0;
      m_cy_r <= '0;
    end else begin
      m_cx_r <= cx0_r + W'(i_x) * step_r;
      m_cy_r <= cy0_r + W'(i_y) * step_r;
    end
  end

  assign zx_a[0]  = '0;
  assign zy_a[0]  = '0;
  assign cx_a[0]  = m_cx_r;
  assign cy_a[0]  = m_cy_r;
  assign cnt_a[0] = '0;
  assign esc_a[0] = 1'b0;

  generate
    for (genvar k = 0; k < N_ITER; k++) begin : g_iter
      mandel_stage #(.W(W), .FRAC(FRAC), .CW(CW)) u_stage (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_zx  (zx_a[k]),
        .i_zy  (zy_a[k]),
        .i_cx  (cx_a[k]),
        .i_cy  (cy_a[k]),
        .i_cnt (cnt_a[k]),
        .i_esc (esc_a[k]),
        .o_zx  (zx_a[k+1]),
        .o_zy  (zy_a[k+1]),
        .o_cx  (cx_a[k+1]),
        .o_cy  (cy_a[k+1]),
        .o_cnt (cnt_a[k+1]),
        .o_esc (esc_a[k+1])
      );
    end
  endgenerate

`ifdef MANDEL_PALETTE_LUT_EN
  logic [23:0] pal_r [0:15];
  logic [3:0]  pal_idx_s;

  generate
    if (CW >= 4) begin : g_idx_top
      assign pal_idx_s = cnt_a[N_ITER][CW-1 -: 4];
    end else begin : g_idx_pad
      assign pal_idx_s = 4'(cnt_a[N_ITER]);
    end
  endgenerate

  // Palette register file, preset to the fixed gradient.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        pal_r[i] <= gradient(8'(i), CW);
      end
    end else if (i_pal_we) begin
      pal_r[i_pal_addr] <= i_pal_data;
    end else begin
      pal_r <= pal_r;
    end
  end

  assign esc_colour_s = pal_r[pal_idx_s];
`else
  assign esc_colour_s = gradient(8'(cnt_a[N_ITER]), CW);
`endif

  // Pixels that never escaped are in the set and drawn black.
  always_comb begin
    if (esc_a[N_ITER]) begin
      colour_s = esc_colour_s;
    end else begin
      colour_s = 24'h000000;
    end
  end

  // Colour stage and sync delay line share the same L-deep timing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_sr_r <= '0;
      hs_sr_r <= '0;
      vs_sr_r <= '0;
      bgr_r   <= 24'h000000;
    end else begin
      de_sr_r <= {de_sr_r[L-2:0], i_de};
      hs_sr_r <= {hs_sr_r[L-2:0], i_hs};
      vs_sr_r <= {vs_sr_r[L-2:0], i_vs};
      if (de_sr_r[L-2]) begin
        bgr_r <= colour_s;
      end else begin
        bgr_r <= 24'h000000;
      end
    end
  end

  assign o_de  = de_sr_r[L-1];
  assign o_hs  = hs_sr_r[L-1];
  assign o_vs  = vs_sr_r[L-1];
  assign o_bgr = bgr_r;

endmodule

// File: tb/tb_mandelbrot_image_gen.sv
// tb_mandelbrot_image_gen: directed vectors with hand-computed colours, checked every cycle.
module tb_mandelbrot_image_gen;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int W  = 18;
  localparam int L  = 18;
  localparam logic [W-1:0] C_ZERO    = 18'd0;
  localparam logic [W-1:0] C_QUARTER = 18'd2048;
  localparam logic [W-1:0] C_ONE     = 18'd8192;
  localparam logic [W-1:0] C_TWO     = 18'd16384;
  localparam logic [W-1:0] C_THREE   = 18'd24576;
  localparam logic [W-1:0] C_MTWO    = 18'h3C000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, de, hs, vs;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [W-1:0]  cx0, cy0, step;
  logic          o_de, o_hs, o_vs;
  logic [23:0]   o_bgr;
  logic          pal_we;
  logic [3:0]    pal_addr;
  logic [23:0]   pal_data;

  mandelbrot_image_gen dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef MANDEL_PALETTE_LUT_EN
    .i_pal_we   (pal_we),
    .i_pal_addr (pal_addr),
    .i_pal_data (pal_data),
`endif
    .i_de       (de),
    .i_hs       (hs),
    .i_vs       (vs),
    .i_x        (px),
    .i_y        (py),
    .i_cx0      (cx0),
    .i_cy0      (cy0),
    .i_step     (step),
    .o_de       (o_de),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_bgr      (o_bgr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_de = -1;
  int first_ode = -1;

  logic        h_de  [0:2047];
  logic        h_hs  [0:2047];
  logic        h_vs  [0:2047];
  logic [23:0] h_bgr [0:2047];
  logic [W-1:0] sh_cx0, sh_cy0, sh_step;
  logic         prev_vs;
  logic [23:0]  pal_m [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Escape counts worked out by hand for the points used below; 0 means in the set.
  function automatic logic [23:0] exp_colour(input logic [W-1:0] cre, input logic [W-1:0] cim);
    int cnt;
    logic [23:0] col;
    if (cre == C_THREE && cim == C_ZERO) cnt = 1;
    else if (cre == C_TWO && cim == C_ZERO) cnt = 2;
    else if (cre == C_ZERO && cim == C_TWO) cnt = 2;
    else if (cre == C_ONE && cim == C_ZERO) cnt = 3;
    else if (cim == C_ZERO && (cre == C_ZERO || cre == C_MTWO || cre == C_QUARTER)) cnt = 0;
    else cnt = -1;
`ifdef MANDEL_PALETTE_LUT_EN
    case (cnt)
      0:       col = 24'h000000;
      1, 2, 3: col = pal_m[cnt >> 1];
      default: col = 24'hBADBAD;
    endcase
`else
    case (cnt)
      0:       col = 24'h000000;
      1:       col = 24'h40F708;
      2:       col = 24'h40EF10;
      3:       col = 24'h40E718;
      default: col = 24'hBADBAD;
    endcase
`endif
    return col;
  endfunction

  task automatic cyc_step(input logic r, input logic d, input logic h, input logic v,
                          input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [W-1:0] cre, cim;
    int src;
    rst = r; de = d; hs = h; vs = v; px = x; py = y;
    if (r) begin
      for (int k = 0; k < L; k++) begin
        if (cyc - k >= 0) begin
          h_de[cyc-k] = 1'b0; h_hs[cyc-k] = 1'b0; h_vs[cyc-k] = 1'b0; h_bgr[cyc-k] = 24'h0;
        end
      end
      sh_cx0 = '0; sh_cy0 = '0; sh_step = '0; prev_vs = 1'b0;
    end else begin
      cre = sh_cx0 + W'(x) * sh_step;
      cim = sh_cy0 + W'(y) * sh_step;
      h_de[cyc] = d; h_hs[cyc] = h; h_vs[cyc] = v;
      h_bgr[cyc] = d ? exp_colour(cre, cim) : 24'h000000;
      if (v && !prev_vs) begin
        sh_cx0 = cx0; sh_cy0 = cy0; sh_step = step;
      end
      prev_vs = v;
      if (d && first_de < 0) first_de = cyc;
    end
    @(posedge clk);
    #1;
    src = cyc - L + 1;
    if (src < 0) begin
      check("o_de", 32'(o_de), 32'd0);
      check("o_hs", 32'(o_hs), 32'd0);
      check("o_vs", 32'(o_vs), 32'd0);
      check("o_bgr", 32'(o_bgr), 32'd0);
    end else begin
      check("o_de", 32'(o_de), 32'(h_de[src]));
      check("o_hs", 32'(o_hs), 32'(h_hs[src]));
      check("o_vs", 32'(o_vs), 32'(h_vs[src]));
      check("o_bgr", 32'(o_bgr), 32'(h_bgr[src]));
    end
    if (o_de === 1'b1 && first_ode < 0) first_ode = cyc;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic frame(input int rows, input int cols, input int tear_row, input logic [W-1:0] tear_val);
    for (int i = 0; i < 2; i++) cyc_step(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    idle(3);
    for (int r = 0; r < rows; r++) begin
      if (r == tear_row) cx0 = tear_val;
      for (int c = 0; c < cols; c++) cyc_step(1'b0, 1'b1, 1'b0, 1'b0, XW'(c % 4), '0);
      for (int i = 0; i < 2; i++) cyc_step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    end
  endtask

  initial begin
    pal_we = 1'b0; pal_addr = 4'd0; pal_data = 24'h0;
    pal_m[0] = 24'h40FF00;
    pal_m[1] = 24'h40F708;
    for (int i = 2; i < 16; i++) pal_m[i] = 24'h000000;
    prev_vs = 1'b0; sh_cx0 = '0; sh_cy0 = '0; sh_step = '0;

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      cx0 = 18'($urandom); cy0 = 18'($urandom); step = 18'($urandom);
      cyc_step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom));
    end

    // Origin in the set, also the latency reference frame.
    cx0 = C_ZERO; cy0 = C_ZERO; step = C_ZERO;
    frame(4, 8, -1, C_ZERO);

    // Immediate escape, then a mid-frame tear attempt that must not show.
    cx0 = C_THREE;
    frame(2, 8, -1, C_ZERO);
    frame(3, 8, 1, C_ONE);
    frame(2, 8, -1, C_ZERO);
    cx0 = C_TWO;    frame(1, 8, -1, C_ZERO);
    cx0 = C_MTWO;   frame(1, 8, -1, C_ZERO);
    cx0 = C_QUARTER; frame(1, 8, -1, C_ZERO);

    // Per-pixel mapping through step, plus an imaginary-axis point.
    cx0 = C_ZERO; step = C_ONE;
    frame(2, 8, -1, C_ZERO);
    cyc_step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd2);
    idle(2);

    // Random sync pattern.
    for (int i = 0; i < 60; i++)
      cyc_step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom_range(0, 3)), '0);

    // Reset in the middle of active video.
    cx0 = C_THREE; step = C_ZERO;
    frame(1, 6, -1, C_ZERO);
    for (int i = 0; i < 5; i++) cyc_step(1'b0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
    for (int i = 0; i < 2; i++) cyc_step(1'b1, 1'b1, 1'b0, 1'b0, 10'd1, '0);
    for (int i = 0; i < 8; i++) cyc_step(1'b0, 1'b1, 1'b0, 1'b0, 10'd1, '0);
    frame(1, 8, -1, C_ZERO);

`ifdef MANDEL_PALETTE_LUT_EN
    idle(L + 2);
    pal_we = 1'b1; pal_addr = 4'd0; pal_data = 24'h123456;
    idle(1);
    pal_m[0] = 24'h123456;
    pal_addr = 4'd1; pal_data = 24'h654321;
    idle(1);
    pal_m[1] = 24'h654321;
    pal_we = 1'b0;
    cx0 = C_ZERO; step = C_ONE;
    frame(2, 8, -1, C_ZERO);
`endif

    idle(L + 2);
    check("latency", 32'(first_ode - first_de + 1), 32'd18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
